uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 14 +
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// uart_tx_if : byte handshake between a producer and the UART transmitter.
// Revision   : 1.0
// ============================================================================
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx  : 8N1 serial transmitter fed by a small byte FIFO.
// Revision : 1.0
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  wire                          clk,
  input  wire                          rst,
  uart_tx_if.slave                     tx,
  output logic                         serial_tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int                 c_ptr_w     = $clog2(FIFO_DEPTH);
  localparam int                 c_cnt_w     = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
  localparam logic [15:0]        c_baud_last = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [15:0]          r_baud;
  logic [2:0]           r_bit;
  logic [7:0]           r_shift;
  logic                 r_serial;
  logic                 r_busy;

  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_baud_done;

  // Ready depends only on the registered count, so a pop cannot free a slot
  // for a push on the same edge.
  assign w_ready     = (r_count < c_depth);
  assign w_push      = tx.tx_valid && w_ready;
  assign w_baud_done = (r_baud == c_baud_last);
  assign w_pop       = (r_count != '0) &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));

  assign tx.tx_ready = w_ready;
  assign serial_tx   = r_serial;
  assign busy        = r_busy;
  assign fifo_count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx.tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_serial <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_state  <= S_START;
            r_serial <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud   <= '0;
            r_bit    <= '0;
            r_state  <= S_DATA;
            r_serial <= r_shift[0];
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state  <= S_STOP;
              r_serial <= 1'b1;
            end else begin
              r_bit    <= r_bit + 3'd1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_serial <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (w_pop) begin
              r_shift  <= r_mem[r_rd_ptr];
              r_state  <= S_START;
              r_serial <= 1'b0;
            end else begin
              r_state  <= S_IDLE;
              r_serial <= 1'b1;
              r_busy   <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : directed bench for uart_tx (CLKS_PER_BIT 10 and 1 instances).
// Revision   : 1.0
// ============================================================================
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       serial_a, busy_a, serial_b, busy_b;
  logic [2:0] count_a, count_b;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_q[$];

  uart_tx_if bus_a ();
  uart_tx_if bus_b ();

  uart_tx #(.CLKS_PER_BIT(10), .FIFO_DEPTH(4)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .tx         (bus_a),
    .serial_tx  (serial_a),
    .busy       (busy_a),
    .fifo_count (count_a)
  );

  uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .tx         (bus_b),
    .serial_tx  (serial_b),
    .busy       (busy_b),
    .fifo_count (count_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at cycle 0 of a frame; returns at cycle 0 of whatever follows it.
  task automatic check_frame(input logic [7:0] d);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 100; i++) begin
      check($sformatf("frame_%02h_bit_c%0d", d, i), 32'(serial_a), 32'(f[i/10]));
      check($sformatf("frame_%02h_busy_c%0d", d, i), 32'(busy_a), 32'd1);
      tick();
    end
  endtask

  // Loopback receiver: mid-bit sampling of the CLKS_PER_BIT=10 line.
  initial begin : rx_mon
    logic [7:0] d;
    logic       abort;
    logic       stop;
    forever begin
      tick();
      if (!rst && serial_a === 1'b0) begin
        d     = '0;
        abort = 1'b0;
        stop  = 1'b0;
        for (int c = 1; c < 100; c++) begin
          tick();
          if (rst) abort = 1'b1;
          if (c >= 15 && c <= 85 && (c % 10) == 5) d = {serial_a, d[7:1]};
          if (c == 95) stop = serial_a;
        end
        if (!abort && stop) rx_q.push_back(d);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [19:0] b_exp;
    logic        quiet;

    rst = 1'b1;
    bus_a.tx_valid = 1'b0;  bus_a.tx_data = 8'h00;
    bus_b.tx_valid = 1'b0;  bus_b.tx_data = 8'h00;
    repeat (3) tick();

    check("rst_serial_a", 32'(serial_a), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_count_a", 32'(count_a), 32'd0);
    check("rst_ready_a", 32'(bus_a.tx_ready), 32'd1);
    check("rst_serial_b", 32'(serial_b), 32'd1);
    rst = 1'b0;
    tick();

    // Single byte, data changed right after acceptance.
    bus_a.tx_data = 8'hAC;  bus_a.tx_valid = 1'b1;
    tick();
    check("single_count", 32'(count_a), 32'd1);
    check("single_pre_serial", 32'(serial_a), 32'd1);
    check("single_pre_busy", 32'(busy_a), 32'd0);
    bus_a.tx_valid = 1'b0;  bus_a.tx_data = 8'h00;
    tick();
    check_frame(8'hAC);
    check("single_post_serial", 32'(serial_a), 32'd1);
    check("single_post_busy", 32'(busy_a), 32'd0);

    // Five bytes back-to-back, contiguous frames.
    rx_q.delete();
    bus_a.tx_data = 8'hAC;  bus_a.tx_valid = 1'b1;
    tick();
    fork
      begin
        tick();
        for (int k = 0; k < 5; k++) check_frame(8'(8'hAC + k));
      end
      begin
        bus_a.tx_data = 8'hAD; tick();
        bus_a.tx_data = 8'hAE; tick();
        bus_a.tx_data = 8'hAF; tick();
        bus_a.tx_data = 8'hB0; tick();
        check("burst_count_full", 32'(count_a), 32'd4);
        check("burst_ready_low", 32'(bus_a.tx_ready), 32'd0);
        bus_a.tx_valid = 1'b0;
      end
    join
    check("burst_idle_serial", 32'(serial_a), 32'd1);
    check("burst_idle_busy", 32'(busy_a), 32'd0);
    check("burst_rx_size", 32'(rx_q.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      check($sformatf("burst_rx_%0d", k), 32'((k < rx_q.size()) ? rx_q[k] : 8'hxx), 32'(8'hAC + k));

    // tx_valid held high: 5 accepted, refused push on the full-queue pop edge.
    rx_q.delete();
    bus_a.tx_valid = 1'b1;
    bus_a.tx_data = 8'h11; tick();
    check("hold_count_1", 32'(count_a), 32'd1);
    bus_a.tx_data = 8'h22; tick();
    check("hold_count_popped", 32'(count_a), 32'd1);
    check("hold_start", 32'(serial_a), 32'd0);
    bus_a.tx_data = 8'h33; tick();
    bus_a.tx_data = 8'h44; tick();
    bus_a.tx_data = 8'h55; tick();
    check("hold_count_full", 32'(count_a), 32'd4);
    check("hold_ready_low", 32'(bus_a.tx_ready), 32'd0);
    bus_a.tx_data = 8'h66;
    repeat (96) tick();
    check("hold_prepop_count", 32'(count_a), 32'd4);
    check("hold_prepop_stop", 32'(serial_a), 32'd1);
    tick();
    check("hold_pop_count", 32'(count_a), 32'd3);
    check("hold_pop_ready", 32'(bus_a.tx_ready), 32'd1);
    check("hold_pop_start", 32'(serial_a), 32'd0);
    tick();
    check("hold_accept_count", 32'(count_a), 32'd4);
    bus_a.tx_valid = 1'b0;  bus_a.tx_data = 8'h00;
    repeat (500) tick();
    check("hold_drain_busy", 32'(busy_a), 32'd0);
    check("hold_drain_count", 32'(count_a), 32'd0);
    check("hold_rx_size", 32'(rx_q.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("hold_rx_%0d", k), 32'((k < rx_q.size()) ? rx_q[k] : 8'hxx), 32'(8'h11 * (k + 1)));

    // Reset during data bit 3 of 0xA5 with two bytes queued.
    rx_q.delete();
    bus_a.tx_valid = 1'b1;
    bus_a.tx_data = 8'hA5; tick();
    bus_a.tx_data = 8'hC3; tick();
    bus_a.tx_data = 8'h3C; tick();
    bus_a.tx_valid = 1'b0;
    repeat (43) tick();
    check("midrst_pre_bit3", 32'(serial_a), 32'd0);
    check("midrst_pre_count", 32'(count_a), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("midrst_serial", 32'(serial_a), 32'd1);
    check("midrst_count", 32'(count_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_ready", 32'(bus_a.tx_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (serial_a !== 1'b1 || busy_a !== 1'b0) quiet = 1'b0;
    end
    check("postrst_quiet", 32'(quiet), 32'd1);
    check("postrst_rx_empty", 32'(rx_q.size()), 32'd0);

    // First push accepted on the first edge after reset release.
    rst = 1'b1;
    tick();
    rst = 1'b0;  bus_a.tx_valid = 1'b1;  bus_a.tx_data = 8'h96;
    tick();
    check("first_push_count", 32'(count_a), 32'd1);
    bus_a.tx_valid = 1'b0;
    tick();
    check("first_push_start", 32'(serial_a), 32'd0);
    check("first_push_busy", 32'(busy_a), 32'd1);
    repeat (100) tick();
    check("first_push_idle", 32'(busy_a), 32'd0);
    check("first_push_rx", 32'((rx_q.size() == 1) ? rx_q[0] : 8'hxx), 32'h96);

    // CLKS_PER_BIT = 1: 0x00 then 0xFF, 20 contiguous one-cycle bits.
    bus_b.tx_valid = 1'b1;
    bus_b.tx_data = 8'h00; tick();
    bus_b.tx_data = 8'hFF; tick();
    bus_b.tx_valid = 1'b0;
    b_exp = 20'b1_11111111_0_1_00000000_0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("fast_bit_c%0d", i), 32'(serial_b), 32'(b_exp[i]));
      check($sformatf("fast_busy_c%0d", i), 32'(busy_b), 32'd1);
      tick();
    end
    check("fast_idle_serial", 32'(serial_b), 32'd1);
    check("fast_idle_busy", 32'(busy_b), 32'd0);
    check("fast_idle_count", 32'(count_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
